// File: rtl/matrix_dma_if.sv
// Wishbone classic bus bundle shared by the DMA register port and its
// memory-side master port.
//   cyc, stb, we : cycle, strobe and write enable (master -> slave)
//   sel          : byte enables (master -> slave)
//   adr          : word address, AW bits wide (master -> slave)
//   dat_w        : write data (master -> slave)
//   dat_r        : read data (slave -> master)
//   ack          : acknowledge (slave -> master)
// The register port ignores byte enables, so the slave view leaves sel out.
interface matrix_dma_if #(
  parameter int AW = 32
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [3:0]    sel;
  logic [AW-1:0] adr;
  logic [31:0]   dat_w;
  logic [31:0]   dat_r;
  logic          ack;

  modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/matrix_dma.sv
// Word-copy DMA engine that moves COUNT words from SRC to DST (for example
// into the LED matrix frame buffer), one read/write pair at a time, with a
// fixed idle gap after every master-port acknowledge.
// Ports:
//   clk_i  : sole clock, rising edge
//   rst_i  : asynchronous active-high reset
//   s      : register port (slave), 2-bit address
//            0 SRC, 1 DST, 2 COUNT, 3 CTRL (write) / STATUS (read)
//   m      : memory master port, 32-bit word address, sel fixed to 4'hf
//   irq_o  : completion interrupt, level, mirrors the done flag
module matrix_dma #(
  parameter int unsigned GAP = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  matrix_dma_if.slave  s,
  matrix_dma_if.master m,
  output logic         irq_o
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] RGAP = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] WGAP = 3'd4;

  localparam logic [3:0]  GAP_LAST  = 4'(GAP - 1);
  localparam logic [9:0]  COUNT_MAX = 10'd512;

  logic [2:0]  state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] data_q, data_d;
  logic [31:0] s_dat_q, s_dat_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [3:0]  gap_q, gap_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;
  logic        s_ack_q, s_ack_d;

  logic        busy;
  logic        reg_wr;
  logic [9:0]  cnt_wdata;

  assign busy      = (state_q != IDLE);
  // A new register access is accepted only while ack is low, which makes a
  // held strobe acknowledge every other cycle.
  assign s_ack_d   = s.cyc & s.stb & ~s_ack_q;
  assign reg_wr    = s_ack_d & s.we;
  assign cnt_wdata = (s.dat_w[9:0] > COUNT_MAX) ? COUNT_MAX : s.dat_w[9:0];

  // Register-port writes are applied first; the transfer sequencer below
  // runs afterwards so that a completion on the same edge as a done-clear
  // still reports done, and leaving WGAP always drops a pending abort.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    done_d  = done_q;
    abort_d = abort_q;
    s_dat_d = s_dat_q;

    if (s_ack_d) begin
      case (s.adr)
        2'd0:    s_dat_d = src_q;
        2'd1:    s_dat_d = dst_q;
        2'd2:    s_dat_d = {22'd0, cnt_q};
        default: s_dat_d = {30'd0, done_q, busy};
      endcase
    end

    if (reg_wr) begin
      case (s.adr)
        2'd0: if (!busy) src_d = s.dat_w;
        2'd1: if (!busy) dst_d = s.dat_w;
        2'd2: if (!busy) cnt_d = cnt_wdata;
        default: begin
          if (s.dat_w[2]) done_d = 1'b0;
          if (s.dat_w[1] && busy) abort_d = 1'b1;
          if (s.dat_w[0] && !busy) begin
            done_d = 1'b0;
            if (cnt_q != 10'd0) state_d = RD;
            else                done_d  = 1'b1;
          end
        end
      endcase
    end

    case (state_q)
      RD: begin
        if (m.ack) begin
          data_d  = m.dat_r;
          gap_d   = 4'd0;
          state_d = RGAP;
        end
      end
      RGAP: begin
        if (gap_q == GAP_LAST) state_d = WR;
        else                   gap_d   = gap_q + 4'd1;
      end
      WR: begin
        if (m.ack) begin
          src_d   = src_q + 32'd1;
          dst_d   = dst_q + 32'd1;
          cnt_d   = cnt_q - 10'd1;
          gap_d   = 4'd0;
          state_d = WGAP;
        end
      end
      WGAP: begin
        if (gap_q != GAP_LAST) begin
          gap_d = gap_q + 4'd1;
        end else if (cnt_q == 10'd0 || abort_q) begin
          state_d = IDLE;
          abort_d = 1'b0;
          if (cnt_q == 10'd0) done_d = 1'b1;
        end else begin
          state_d = RD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      s_ack_q <= 1'b0;
      s_dat_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      s_ack_q <= s_ack_d;
      s_dat_q <= s_dat_d;
    end
  end

  // Bus outputs decode registered state only, so nothing on the master
  // side depends combinationally on m.ack, and SRC/DST/data cannot change
  // while a strobe is up.
  assign m.cyc   = (state_q == RD) || (state_q == WR);
  assign m.stb   = m.cyc;
  assign m.we    = (state_q == WR);
  assign m.sel   = 4'hf;
  assign m.adr   = (state_q == WR) ? dst_q : src_q;
  assign m.dat_w = data_q;

  assign s.ack   = s_ack_q;
  assign s.dat_r = s_dat_q;
  assign irq_o   = done_q;

endmodule

// File: tb/tb_matrix_dma.sv
// Self-checking bench for matrix_dma: a ROM-like memory responder with
// configurable ack latency and stray acks, a bus monitor for gap and
// stability, and directed plus randomized transfers compared against an
// address/data model of what a word copy must produce.
module tb_matrix_dma;
  localparam int GAP = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic irq;

  always #5 clk = ~clk;

  matrix_dma_if #(.AW(2))  regBus ();
  matrix_dma_if #(.AW(32)) memBus ();

  matrix_dma #(.GAP(GAP)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .s     (regBus),
    .m     (memBus),
    .irq_o (irq)
  );

  int tests = 0;
  int failures = 0;
  int ackDelay = 1;
  int strayAcks = 0;
  logic [31:0] rdLog[$];
  logic [31:0] wrAdrLog[$];
  logic [31:0] wrDatLog[$];
  int stableErr = 0;
  int idleRun = 0;
  int minIdle = 1000;
  bit seenCyc = 0;
  bit cycEver = 0;
  bit prevCyc = 0;
  logic [31:0] capAdr, capDat;
  logic capWe;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] romVal(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a5a_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks after ackDelay cycles, then optional stray acks.
  initial begin
    memBus.ack = 1'b0;
    memBus.dat_r = '0;
    forever begin
      @(negedge clk);
      if (memBus.cyc && memBus.stb) begin
        for (int k = 0; k < ackDelay; k++) @(negedge clk);
        if (memBus.cyc) begin
          if (memBus.we) begin
            wrAdrLog.push_back(memBus.adr);
            wrDatLog.push_back(memBus.dat_w);
          end else begin
            rdLog.push_back(memBus.adr);
            memBus.dat_r = romVal(memBus.adr);
          end
          memBus.ack = 1'b1;
          @(negedge clk);
          for (int k = 0; k < strayAcks; k++) begin
            memBus.ack = 1'b1;
            memBus.dat_r = 32'hbad0_0000 | 32'(k);
            @(negedge clk);
          end
          memBus.ack = 1'b0;
        end
      end
    end
  end

  // Bus monitor: idle run between strobes and stability during a strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (memBus.cyc) begin
        cycEver = 1;
        if (memBus.stb !== 1'b1 || memBus.sel !== 4'hf) stableErr++;
        if (!prevCyc) begin
          if (seenCyc && idleRun < minIdle) minIdle = idleRun;
          seenCyc = 1;
          capAdr = memBus.adr;
          capWe = memBus.we;
          capDat = memBus.dat_w;
        end else if (memBus.adr !== capAdr || memBus.we !== capWe || memBus.dat_w !== capDat) begin
          stableErr++;
        end
        idleRun = 0;
      end else begin
        if (memBus.stb !== 1'b0) stableErr++;
        idleRun++;
      end
      prevCyc = memBus.cyc;
    end
  end

  task automatic applyStimulus(input logic [1:0] a, input logic we, input logic [31:0] d,
                               output logic [31:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    regBus.cyc = 1'b1; regBus.stb = 1'b1; regBus.we = we;
    regBus.adr = a; regBus.dat_w = d;
    do begin
      @(negedge clk);
      n++;
    end while (!regBus.ack && n < 20);
    rd = regBus.dat_r;
    regBus.cyc = 1'b0; regBus.stb = 1'b0; regBus.we = 1'b0;
    check("s_ack latency", 32'(n), 32'd1);
  endtask

  task automatic wbWrite(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    applyStimulus(a, 1'b1, d, dummy);
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    applyStimulus(a, 1'b0, 32'd0, v);
    check(tag, v, exp);
  endtask

  task automatic waitIdle();
    logic [31:0] st;
    int polls;
    polls = 0;
    do begin
      applyStimulus(2'd3, 1'b0, 32'd0, st);
      polls++;
    end while (st[0] && polls < 400);
    check("waitIdle busy", {31'd0, st[0]}, 32'd0);
  endtask

  task automatic clearLogs();
    rdLog.delete(); wrAdrLog.delete(); wrDatLog.delete();
    seenCyc = 0; minIdle = 1000; stableErr = 0; cycEver = 0;
  endtask

  task automatic runTransfer(input logic [31:0] src, input logic [31:0] dst, input int n);
    clearLogs();
    wbWrite(2'd0, src);
    wbWrite(2'd1, dst);
    wbWrite(2'd2, 32'(n));
    wbWrite(2'd3, 32'd1);
    waitIdle();
    check("write count", 32'(wrAdrLog.size()), 32'(n));
    check("read count", 32'(rdLog.size()), 32'(n));
    for (int i = 0; i < n && i < wrAdrLog.size() && i < rdLog.size(); i++) begin
      check("read adr", rdLog[i], src + 32'(i));
      check("write adr", wrAdrLog[i], dst + 32'(i));
      check("write data", wrDatLog[i], romVal(src + 32'(i)));
    end
    check("min idle gap", 32'(minIdle), 32'(GAP));
    check("bus stability", 32'(stableErr), 32'd0);
    check("irq after done", {31'd0, irq}, 32'd1);
    checkOutput("STATUS done", 2'd3, 32'h2);
    checkOutput("SRC final", 2'd0, src + 32'(n));
    checkOutput("DST final", 2'd1, dst + 32'(n));
    checkOutput("COUNT final", 2'd2, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int acks;
    int waitN;
    logic [31:0] v, src, dst;
    int n;

    regBus.cyc = 0; regBus.stb = 0; regBus.we = 0; regBus.sel = 4'hf;
    regBus.adr = '0; regBus.dat_w = '0;
    #1 rst = 1'b1;
    #22 rst = 1'b0;

    // Reset state
    check("reset m_cyc", {31'd0, memBus.cyc}, 32'd0);
    check("reset irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 4; a++) checkOutput("reset reg", 2'(a), 32'd0);

    // Held strobe: ack every other cycle
    @(negedge clk);
    regBus.cyc = 1; regBus.stb = 1; regBus.we = 0; regBus.adr = 2'd3;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (regBus.ack) acks++;
    end
    regBus.cyc = 0; regBus.stb = 0;
    check("held strobe acks", 32'(acks), 32'd4);

    // Basic copy with 1-cycle ack latency
    ackDelay = 1; strayAcks = 0;
    runTransfer(32'h100, 32'h0, 3);

    // Delayed ack with two trailing stray acks
    ackDelay = 2; strayAcks = 2;
    runTransfer(32'h800, 32'h900, 7);

    // Randomized transfers, first one wraps SRC past 2^32
    for (int t = 0; t < 4; t++) begin
      src = (t == 0) ? 32'hffff_fffe : $urandom;
      dst = (t == 1) ? 32'hffff_ffff : $urandom;
      n = $urandom_range(1, 6);
      ackDelay = $urandom_range(0, 3);
      strayAcks = $urandom_range(0, 2);
      runTransfer(src, dst, n);
    end

    // COUNT == 0 start: done without bus activity
    ackDelay = 1; strayAcks = 0;
    wbWrite(2'd3, 32'h4);
    check("done cleared", {31'd0, irq}, 32'd0);
    wbWrite(2'd2, 32'd0);
    cycEver = 0;
    wbWrite(2'd3, 32'h1);
    @(negedge clk);
    check("zero count irq", {31'd0, irq}, 32'd1);
    checkOutput("zero count STATUS", 2'd3, 32'h2);
    check("zero count no cyc", {31'd0, cycEver}, 32'd0);

    // Abort during the second read
    ackDelay = 4; strayAcks = 0;
    clearLogs();
    wbWrite(2'd0, 32'h2000);
    wbWrite(2'd1, 32'h3000);
    wbWrite(2'd2, 32'd5);
    wbWrite(2'd3, 32'h1);
    waitN = 0;
    while (!(wrAdrLog.size() == 1 && memBus.cyc && !memBus.we) && waitN < 200) begin
      @(negedge clk);
      waitN++;
    end
    check("reach 2nd RD", {31'd0, waitN < 200}, 32'd1);
    wbWrite(2'd3, 32'h2);
    waitIdle();
    check("abort writes", 32'(wrAdrLog.size()), 32'd2);
    check("abort reads", 32'(rdLog.size()), 32'd2);
    checkOutput("abort COUNT", 2'd2, 32'd3);
    checkOutput("abort STATUS", 2'd3, 32'h0);
    checkOutput("abort SRC", 2'd0, 32'h2002);
    check("abort irq", {31'd0, irq}, 32'd0);

    // Start, SRC and COUNT writes while busy are ignored
    ackDelay = 2;
    clearLogs();
    wbWrite(2'd0, 32'h4000);
    wbWrite(2'd1, 32'h5000);
    wbWrite(2'd2, 32'd4);
    wbWrite(2'd3, 32'h1);
    waitN = 0;
    while (!memBus.cyc && waitN < 50) begin @(negedge clk); waitN++; end
    wbWrite(2'd3, 32'h1);
    wbWrite(2'd0, 32'hdead_beef);
    wbWrite(2'd2, 32'd1);
    waitIdle();
    check("busy-ignore writes", 32'(wrAdrLog.size()), 32'd4);
    for (int i = 0; i < 4 && i < wrDatLog.size(); i++)
      check("busy-ignore data", wrDatLog[i], romVal(32'h4000 + 32'(i)));
    checkOutput("busy-ignore SRC", 2'd0, 32'h4004);

    // COUNT clamping and width
    for (int i = 0; i < 4; i++) begin
      v = (i == 0) ? 32'd600 : (i == 1) ? 32'd512 : (i == 2) ? 32'd511 : 32'h0000_0c05;
      wbWrite(2'd2, v);
      checkOutput("COUNT clamp", 2'd2, (v[9:0] > 10'd512) ? 32'd512 : {22'd0, v[9:0]});
    end

    // Asynchronous reset during a write strobe
    ackDelay = 6;
    wbWrite(2'd0, 32'h6000);
    wbWrite(2'd1, 32'h7000);
    wbWrite(2'd2, 32'd3);
    wbWrite(2'd3, 32'h1);
    waitN = 0;
    while (!(memBus.cyc && memBus.we) && waitN < 200) begin @(negedge clk); waitN++; end
    check("reach WR", {31'd0, waitN < 200}, 32'd1);
    #2 rst = 1'b1;
    #1 check("async reset m_cyc", {31'd0, memBus.cyc}, 32'd0);
    #4 rst = 1'b0;
    check("reset irq after", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 4; a++) checkOutput("post-reset reg", 2'(a), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
